bin_to_digits: RTL and testbench
================================

Name: bin_to_digits

Overview:
- Upstream feeder for the 8-digit seven-segment scanner. Converts a binary value (e.g. the DAC code or a derived voltage) into eight 4-bit digit codes, bit_7 (leftmost) to bit_0 (rightmost).
- Conversion is iterative double-dabble (shift-add-3), one binary bit per clock.
- Adds leading-zero blanking, a minus sign and overflow indication, using the scanner's code set: 0-9 digits, 10 blank, 11 dash.
- Outputs are held stable between conversions, so the scanner never displays a partial result.

Parameters:
- BIN_W, 27, width of the binary input; legal range 4..27 (27 bits covers 99_999_999).
- BLANK_LZ, 1, 1 blanks leading zeros; 0 shows all eight digits with zero padding.

Ports:
- sclk  in  1  system clock, 50 MHz.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  BIN_W  unsigned magnitude; latched on an accepted start.
- neg  in  1  sign flag (1 = negative); latched with bin.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; the digit outputs are updated on the same edge.
- bit_7..bit_0  out  4 each  digit codes; bit_7 is leftmost.

Behaviour:
- Reset: nrst is asynchronous, active-low; the clock is sclk. While in reset: state=IDLE; busy=0; done=0; all bit_* = 4'd10 (blank display); internal shift registers cleared.
- Asserting nrst mid-conversion aborts the conversion. No done pulse is produced and the digits return to blank.
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE:
  - start=1 at edge E0: latch bin/neg, clear the 32-bit BCD accumulator, load the iteration counter, compute the overflow flag, set busy=1, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT: runs BIN_W cycles, on edges E1..E_BIN_W.
  - Each cycle: every BCD nibble >=5 gets +3, then {bcd, bin_sh} shifts left by 1, MSB of bin_sh entering bcd[0].
  - The counter decrements; at terminal count go to FORMAT.
- FORMAT: one cycle, edge E_(BIN_W+1).
  - Registered write of all bit_* from the accumulator with blanking, sign and overflow applied.
  - done=1 for this cycle only; busy=0; go to IDLE.
- Latency: the start edge to the done/output edge is BIN_W+1 edges (28 for the default). Throughput is one conversion per BIN_W+2 cycles; start may be re-asserted in the cycle done is high.
- A start while busy=1 is ignored and is not queued. bin and neg may change freely after acceptance.
- Overflow:
  - neg=0 and bin > 99_999_999, or neg=1 and bin > 9_999_999, produces all eight digits = 11.
  - The comparison zero-extends bin to 27 bits.
- Blanking (BLANK_LZ=1):
  - Digits above the most significant non-zero digit become 10.
  - bit_0 is always shown, so value 0 displays as "0".
- Sign:
  - neg=1 with bin != 0 puts 11 in the position immediately left of the most significant shown digit.
  - With BLANK_LZ=0 the dash goes in bit_7, and bit_7 is otherwise always 0 by the overflow rule.
  - neg=1 with bin=0 displays as unsigned 0 (no "-0").
- Digit outputs change only at the FORMAT edge or at reset.

Decomposition:
- Shared package holds:
  - digit code constants DIG_BLANK=4'd10 and DIG_DASH=4'd11;
  - limits MAX_POS=27'd99_999_999 and MAX_NEG=27'd9_999_999;
  - FSM state encoding.
- One sub-module: dd_add3, a combinational nibble adjust (>=5 adds 3). It is instantiated 8 times inside the shift datapath.
- Sign, blank and overflow formatting stays inline in FORMAT.

Test Plan:
- Reset: assert nrst=0 → all bit_*=10, busy=0, done=0. Release, idle 100 cycles → outputs unchanged.
- Basic conversion: bin=1234, neg=0, start pulse → busy high for 28 cycles. done pulses exactly 28 edges after the start edge, with digits 10,10,10,10,1,2,3,4. Repeat for bin=99_999_999 → 9,9,9,9,9,9,9,9.
- Zero and sign:
  - bin=0, neg=1 → 10×7, then 0.
  - bin=255, neg=1 → 10,10,10,10,11,2,5,5.
  - bin=9_999_999, neg=1 → 11,9,9,9,9,9,9,9.
- Overflow:
  - bin=100_000_000, neg=0 → all eight digits = 11.
  - bin=10_000_000, neg=1 → all eight digits = 11.
- Handshake:
  - Start re-pulsed mid-conversion → ignored, single done, result of the first value.
  - nrst pulsed at cycle 10 of SHIFT → digits blank, busy=0, no done.
  - Back-to-back start on the done cycle → accepted.
- BLANK_LZ=0 build: bin=42, neg=0 → 0,0,0,0,0,0,4,2; bin=42, neg=1 → 11,0,0,0,0,0,4,2.

Source files
------------

// File: rtl/bin_to_digits_pkg.sv
// Shared constants for the binary-to-seven-segment-digit converter:
// scanner digit codes, display limits and FSM state encoding.
package bin_to_digits_pkg;

   localparam logic [3:0] DIG_BLANK = 4'd10;
   localparam logic [3:0] DIG_DASH  = 4'd11;

   localparam int unsigned BIN_MAX_W = 27;
   localparam logic [26:0] MAX_POS   = 27'd99_999_999;
   localparam logic [26:0] MAX_NEG   = 27'd9_999_999;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_FORMAT = 2'd2;

endpackage

// File: rtl/bin_to_digits_if.sv
// Request/result bundle between a value producer and the digit converter.
interface bin_to_digits_if #(
   parameter int unsigned BIN_W = 27
);

   logic             start;
   logic [BIN_W-1:0] bin;
   logic             neg;
   logic             busy;
   logic             done;
   logic [3:0]       bit_7;
   logic [3:0]       bit_6;
   logic [3:0]       bit_5;
   logic [3:0]       bit_4;
   logic [3:0]       bit_3;
   logic [3:0]       bit_2;
   logic [3:0]       bit_1;
   logic [3:0]       bit_0;

   modport master (
      output start, bin, neg,
      input  busy, done, bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0
   );

   modport slave (
      input  start, bin, neg,
      output busy, done, bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0
   );

endinterface

// File: rtl/dd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets +3 before the shift.
module dd_add3 (
   input  logic [3:0] value,
   output logic [3:0] adjusted
);

   assign adjusted = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bin_to_digits.sv
// Iterative binary-to-BCD converter (one bit per clock) feeding the 8-digit scanner,
// with leading-zero blanking, minus sign and overflow dashes applied on the result edge.
module bin_to_digits
   import bin_to_digits_pkg::*;
#(
   parameter int unsigned BIN_W    = 27,
   parameter int unsigned BLANK_LZ = 1
) (
   input logic            sclk,
   input logic            nrst,
   bin_to_digits_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      bcd_q, bcd_d;
   logic [BIN_W-1:0] bin_sh_q, bin_sh_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0][3:0]  dig_q, dig_d;

   logic [31:0]      adj;
   logic [32:0]      shifted;
   logic [26:0]      bin_ext;
   logic [7:0][3:0]  fmt;
   logic [2:0]       msd;
   logic             show_dash;

   for (genvar g = 0; g < 8; g++) begin : g_add3
      dd_add3 u_add3 (
         .value    (bcd_q[4*g +: 4]),
         .adjusted (adj[4*g +: 4])
      );
   end

   // Bit 32 is a ninth decimal digit; such values are already overflow.
   assign shifted = {adj, bin_sh_q[BIN_W-1]};
   assign bin_ext = 27'(bus.bin);

   always_comb begin
      msd = 3'd0;
      for (int unsigned i = 1; i < 8; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = i[2:0];
      end
      show_dash = neg_q && (bcd_q != 32'd0);
      for (int unsigned i = 0; i < 8; i++) begin
         fmt[i[2:0]] = bcd_q[4*i +: 4];
         if (ovf_q) begin
            fmt[i[2:0]] = DIG_DASH;
         end else if (BLANK_LZ != 0) begin
            if (i[2:0] > msd) begin
               fmt[i[2:0]] = (show_dash && (i[3:0] == ({1'b0, msd} + 4'd1))) ? DIG_DASH
                                                                               : DIG_BLANK;
            end
         end else if (show_dash && (i == 7)) begin
            fmt[i[2:0]] = DIG_DASH;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      bin_sh_d = bin_sh_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dig_d    = dig_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               bin_sh_d = bus.bin;
               neg_d    = bus.neg;
               bcd_d    = 32'd0;
               cnt_d    = CNT_W'(BIN_W);
               ovf_d    = bus.neg ? (bin_ext > MAX_NEG) : (bin_ext > MAX_POS);
               busy_d   = 1'b1;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bcd_d    = shifted[31:0];
            bin_sh_d = bin_sh_q << 1;
            ovf_d    = ovf_q | shifted[32];
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_FORMAT;
         end
         ST_FORMAT: begin
            dig_d   = fmt;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bcd_q    <= '0;
         bin_sh_q <= '0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dig_q    <= {8{DIG_BLANK}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         bin_sh_q <= bin_sh_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dig_q    <= dig_d;
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.bit_7 = dig_q[7];
   assign bus.bit_6 = dig_q[6];
   assign bus.bit_5 = dig_q[5];
   assign bus.bit_4 = dig_q[4];
   assign bus.bit_3 = dig_q[3];
   assign bus.bit_2 = dig_q[2];
   assign bus.bit_1 = dig_q[1];
   assign bus.bit_0 = dig_q[0];

endmodule

// File: tb/tb_bin_to_digits.sv
// Directed bench for bin_to_digits: blanking and zero-padded builds side by side,
// checked every cycle against a decimal-arithmetic model plus literal expectations.
module tb_bin_to_digits;

   localparam int unsigned BIN_W = 27;

   logic             sclk = 1'b0;
   logic             nrst = 1'b0;
   logic             start = 1'b0;
   logic [BIN_W-1:0] bin = '0;
   logic             neg = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   always #10 sclk = ~sclk;

   bin_to_digits_if #(.BIN_W(BIN_W)) bus_lz ();
   bin_to_digits_if #(.BIN_W(BIN_W)) bus_nz ();

   assign bus_lz.start = start;
   assign bus_lz.bin   = bin;
   assign bus_lz.neg   = neg;
   assign bus_nz.start = start;
   assign bus_nz.bin   = bin;
   assign bus_nz.neg   = neg;

   bin_to_digits #(.BIN_W(BIN_W), .BLANK_LZ(1)) dut_lz (
      .sclk (sclk),
      .nrst (nrst),
      .bus  (bus_lz)
   );

   bin_to_digits #(.BIN_W(BIN_W), .BLANK_LZ(0)) dut_nz (
      .sclk (sclk),
      .nrst (nrst),
      .bus  (bus_nz)
   );

   logic [31:0] dig_lz, dig_nz;
   assign dig_lz = {bus_lz.bit_7, bus_lz.bit_6, bus_lz.bit_5, bus_lz.bit_4,
                    bus_lz.bit_3, bus_lz.bit_2, bus_lz.bit_1, bus_lz.bit_0};
   assign dig_nz = {bus_nz.bit_7, bus_nz.bit_6, bus_nz.bit_5, bus_nz.bit_4,
                    bus_nz.bit_3, bus_nz.bit_2, bus_nz.bit_1, bus_nz.bit_0};

   // Display text for a signed value, from decimal arithmetic on the value itself.
   function automatic logic [31:0] model(input longint unsigned v, input bit n, input bit blank);
      logic [3:0]      d [8];
      longint unsigned t;
      int              top;
      logic [31:0]     r;
      if ((n && v > 64'd9_999_999) || (!n && v > 64'd99_999_999)) return 32'hBBBB_BBBB;
      t = v;
      for (int i = 0; i < 8; i++) begin
         d[i] = 4'(t % 10);
         t    = t / 10;
      end
      t   = v;
      top = 0;
      while (t >= 10) begin
         t = t / 10;
         top++;
      end
      if (blank) begin
         for (int i = top + 1; i < 8; i++) d[i] = 4'd10;
         if (n && v != 0) d[top+1] = 4'd11;
      end else if (n && v != 0) begin
         d[7] = 4'd11;
      end
      for (int i = 0; i < 8; i++) r[4*i +: 4] = d[i];
      return r;
   endfunction

   // Timing model: a request is taken only when idle, result appears BIN_W+1 edges later.
   int unsigned     m_left;
   logic            m_busy, m_done;
   logic [31:0]     m_dig_lz, m_dig_nz;
   longint unsigned m_val;
   bit              m_neg;

   always @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         m_left   <= 0;
         m_busy   <= 1'b0;
         m_done   <= 1'b0;
         m_dig_lz <= 32'hAAAA_AAAA;
         m_dig_nz <= 32'hAAAA_AAAA;
      end else begin
         m_done <= 1'b0;
         if (m_left == 0) begin
            if (start) begin
               m_left <= BIN_W + 1;
               m_busy <= 1'b1;
               m_val  <= longint'(bin);
               m_neg  <= neg;
            end
         end else if (m_left == 1) begin
            m_left   <= 0;
            m_busy   <= 1'b0;
            m_done   <= 1'b1;
            m_dig_lz <= model(m_val, m_neg, 1'b1);
            m_dig_nz <= model(m_val, m_neg, 1'b0);
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge sclk) begin
      if (check_en) begin
         check("busy_lz", 32'(bus_lz.busy), 32'(m_busy));
         check("done_lz", 32'(bus_lz.done), 32'(m_done));
         check("digits_lz", dig_lz, m_dig_lz);
         check("busy_nz", 32'(bus_nz.busy), 32'(m_busy));
         check("done_nz", 32'(bus_nz.done), 32'(m_done));
         check("digits_nz", dig_nz, m_dig_nz);
      end
   end

   // Called at a falling edge; start is taken on the next rising edge.
   task automatic convert(input string name, input longint unsigned v, input bit n,
                          input logic [31:0] exp_lz, input logic [31:0] exp_nz);
      int k;
      bin   = BIN_W'(v);
      neg   = n;
      start = 1'b1;
      @(negedge sclk);
      start = 1'b0;
      bin   = '1;
      neg   = ~n;
      k     = 0;
      while (!bus_lz.done && k < 40) begin
         @(negedge sclk);
         k++;
      end
      check({name, " latency"}, 32'(k), 32'd28);
      check({name, " lz"}, dig_lz, exp_lz);
      check({name, " nz"}, dig_nz, exp_nz);
   endtask

   task automatic count_dones(input string name, input int cycles);
      int c;
      c = 0;
      repeat (cycles) begin
         @(negedge sclk);
         if (bus_lz.done || bus_nz.done) c++;
      end
      check({name, " no done"}, 32'(c), 32'd0);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge sclk);
      check("reset busy", 32'(bus_lz.busy), 32'd0);
      check("reset done", 32'(bus_lz.done), 32'd0);
      check("reset digits", dig_lz, 32'hAAAA_AAAA);
      check_en = 1'b1;
      nrst     = 1'b1;
      repeat (100) @(negedge sclk);
      check("idle digits", dig_lz, 32'hAAAA_AAAA);

      convert("1234",      1234,        1'b0, 32'hAAAA_1234, 32'h0000_1234);
      convert("max pos",   99_999_999,  1'b0, 32'h9999_9999, 32'h9999_9999);
      convert("neg zero",  0,           1'b1, 32'hAAAA_AAA0, 32'h0000_0000);
      convert("neg 255",   255,         1'b1, 32'hAAAA_B255, 32'hB000_0255);
      convert("max neg",   9_999_999,   1'b1, 32'hB999_9999, 32'hB999_9999);
      convert("ovf pos",   100_000_000, 1'b0, 32'hBBBB_BBBB, 32'hBBBB_BBBB);
      convert("ovf neg",   10_000_000,  1'b1, 32'hBBBB_BBBB, 32'hBBBB_BBBB);
      convert("ovf top",   134_217_727, 1'b0, 32'hBBBB_BBBB, 32'hBBBB_BBBB);
      convert("42",        42,          1'b0, 32'hAAAA_AA42, 32'h0000_0042);
      convert("neg 42",    42,          1'b1, 32'hAAAA_AB42, 32'hB000_0042);

      // A second start mid-conversion must be dropped, not queued.
      bin   = BIN_W'(5678);
      neg   = 1'b0;
      start = 1'b1;
      @(negedge sclk);
      start = 1'b0;
      k     = 0;
      while (!bus_lz.done && k < 40) begin
         @(negedge sclk);
         k++;
         start = (k == 10);
         bin   = (k == 10) ? BIN_W'(1111) : bin;
      end
      start = 1'b0;
      check("ignore latency", 32'(k), 32'd28);
      check("ignore lz", dig_lz, 32'hAAAA_5678);
      check("ignore nz", dig_nz, 32'h0000_5678);
      count_dones("ignore", 40);

      // Back-to-back: the second start lands in the done cycle of the first.
      convert("b2b first",  31_415_926, 1'b0, 32'h3141_5926, 32'h3141_5926);
      convert("b2b second", 7,          1'b1, 32'hAAAA_AAB7, 32'hB000_0007);

      // Reset mid-shift aborts and blanks.
      bin   = BIN_W'(777);
      neg   = 1'b0;
      start = 1'b1;
      @(negedge sclk);
      start = 1'b0;
      repeat (10) @(negedge sclk);
      nrst = 1'b0;
      @(negedge sclk);
      check("abort busy", 32'(bus_lz.busy), 32'd0);
      check("abort digits", dig_lz, 32'hAAAA_AAAA);
      nrst = 1'b1;
      count_dones("abort", 40);
      check("abort digits held", dig_nz, 32'hAAAA_AAAA);

      convert("after abort", 90_000_001, 1'b0, 32'h9000_0001, 32'h9000_0001);

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
